// File: rtl/alu_mc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_mc : multi-cycle ALU, single-cycle logic/arith, iterative    |
// |          unsigned MUL (shift-add) and DIV (restoring).  rev 1.0  |
// +------------------------------------------------------------------+
module alu_mc #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   opcode,
  input  logic [N-1:0] operandA,
  input  logic [N-1:0] operandB,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         C_Flag,
  output logic         O_Flag,
  output logic         N_Flag,
  output logic         Z_Flag
);

  localparam int LW = $clog2(N);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ITER = 1'b1
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [LW-1:0]  r_cnt;
  logic           r_is_div;
  logic [N-1:0]   r_a, r_b;
  logic [2*N-1:0] r_p;
  logic [N-1:0]   r_res;
  logic           r_done, r_c, r_o, r_n, r_z;

  logic           w_accept, w_iter_op, w_last;
  logic [N:0]     w_add, w_sub, w_shl;
  logic [N-1:0]   w_res_s;
  logic           w_c_s, w_o_s;
  logic [N:0]     w_msum, w_rsh, w_rdiff;
  logic [2*N-1:0] w_mul_nxt, w_div_nxt, w_p_nxt;
  logic [N-1:0]   w_fin_res;
  logic           w_fin_c, w_fin_o;

  assign w_accept  = start && (r_state == S_IDLE);
  assign w_iter_op = (opcode[2:1] == 2'b11);
  assign w_last    = (r_cnt == LW'(N-1));

  assign w_add = {1'b0, operandA} + {1'b0, operandB};
  assign w_sub = {1'b0, operandA} - {1'b0, operandB};
  // One extra bit on top catches the last bit shifted out.
  assign w_shl = {1'b0, operandA} << operandB[LW-1:0];

  always_comb begin
    w_res_s = '0;
    w_c_s   = 1'b0;
    w_o_s   = 1'b0;
    case (opcode)
      3'b000: begin
        w_res_s = w_add[N-1:0];
        w_c_s   = w_add[N];
        w_o_s   = (operandA[N-1] == operandB[N-1]) && (w_add[N-1] != operandA[N-1]);
      end
      3'b001: begin
        w_res_s = w_sub[N-1:0];
        w_c_s   = ~w_sub[N];
        w_o_s   = (operandA[N-1] != operandB[N-1]) && (w_sub[N-1] != operandA[N-1]);
      end
      3'b010:  w_res_s = operandA & operandB;
      3'b011:  w_res_s = operandA | operandB;
      3'b100:  w_res_s = operandA ^ operandB;
      3'b101: begin
        w_res_s = w_shl[N-1:0];
        w_c_s   = w_shl[N];
      end
      default: w_res_s = '0;
    endcase
  end

  // MUL: r_p = {partial high, multiplier shifting out}; DIV: r_p = {remainder, quotient}.
  assign w_msum    = {1'b0, r_p[2*N-1:N]} + (r_p[0] ? {1'b0, r_a} : {(N+1){1'b0}});
  assign w_mul_nxt = {w_msum, r_p[N-1:1]};
  assign w_rsh     = {r_p[2*N-1:N], r_p[N-1]};
  assign w_rdiff   = w_rsh - {1'b0, r_b};
  assign w_div_nxt = w_rdiff[N] ? {w_rsh[N-1:0],   r_p[N-2:0], 1'b0}
                                : {w_rdiff[N-1:0], r_p[N-2:0], 1'b1};
  assign w_p_nxt   = r_is_div ? w_div_nxt : w_mul_nxt;

  always_comb begin
    w_fin_res = w_res_s;
    w_fin_c   = w_c_s;
    w_fin_o   = w_o_s;
    if (r_state == S_ITER) begin
      w_fin_res = w_p_nxt[N-1:0];
      w_fin_c   = r_is_div ? 1'b0 : |w_mul_nxt[2*N-1:N];
      w_fin_o   = r_is_div && (r_b == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_iter_op) w_state_nxt = S_ITER;
      S_ITER:  if (w_last)                w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_p      <= '0;
      r_res    <= '0;
      r_done   <= 1'b0;
      r_c      <= 1'b0;
      r_o      <= 1'b0;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_ITER) begin
        r_p   <= w_p_nxt;
        r_cnt <= r_cnt + LW'(1);
      end else if (w_accept && w_iter_op) begin
        r_cnt    <= '0;
        r_is_div <= opcode[0];
        r_a      <= operandA;
        r_b      <= operandB;
        r_p      <= {{N{1'b0}}, (opcode[0] ? operandA : operandB)};
      end
      if ((r_state == S_ITER && w_last) || (w_accept && !w_iter_op)) begin
        r_res  <= w_fin_res;
        r_c    <= w_fin_c;
        r_o    <= w_fin_o;
        r_n    <= w_fin_res[N-1];
        r_z    <= (w_fin_res == '0);
        r_done <= 1'b1;
      end
    end
  end

  assign busy   = (r_state == S_ITER);
  assign done   = r_done;
  assign result = r_res;
  assign C_Flag = r_c;
  assign O_Flag = r_o;
  assign N_Flag = r_n;
  assign Z_Flag = r_z;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_alu_mc : randomized self-checking bench for alu_mc  rev 1.0   |
// +------------------------------------------------------------------+
module tb_alu_mc;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   opcode = 3'b000;
  logic [N-1:0] operandA = '0;
  logic [N-1:0] operandB = '0;
  logic         busy, done, C_Flag, O_Flag, N_Flag, Z_Flag;
  logic [N-1:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  alu_mc #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .operandA(operandA), .operandB(operandB), .busy(busy), .done(done),
    .result(result), .C_Flag(C_Flag), .O_Flag(O_Flag), .N_Flag(N_Flag),
    .Z_Flag(Z_Flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic c, output logic o);
    longint sa, sb, t;
    logic [63:0] p;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0;
    o = 1'b0;
    r = '0;
    case (op)
      3'd0: begin
        p = {32'b0, a} + {32'b0, b};
        r = p[31:0];
        c = p[32];
        t = sa + sb;
        o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      3'd1: begin
        r = a - b;
        c = (a >= b);
        t = sa - sb;
        o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin
        sh = int'(b % 32);
        r = a << sh;
        c = (sh == 0) ? 1'b0 : a[32-sh];
      end
      3'd6: begin
        p = {32'b0, a} * {32'b0, b};
        r = p[31:0];
        c = (p[63:32] != 0);
      end
      default: begin
        if (b == 0) begin
          r = 32'hFFFF_FFFF;
          o = 1'b1;
        end else begin
          r = a / b;
        end
      end
    endcase
  endtask

  logic [31:0] last_res;

  task automatic check_outputs(input string tag, input logic [31:0] er, input logic ec,
                               input logic eo);
    check({tag, "_res"}, result, er);
    check({tag, "_flags"}, {C_Flag, O_Flag, N_Flag, Z_Flag},
          {ec, eo, er[31], (er == 0)});
  endtask

  // Issues one op; returns during its done cycle (sampled 1 time unit past the edge).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [31:0] er;
    logic ec, eo;
    int cyc;
    model(op, a, b, er, ec, eo);
    @(negedge clk);
    start = 1'b1; opcode = op; operandA = a; operandB = b;
    @(posedge clk); #1;
    start = 1'b0; opcode = 3'($urandom); operandA = $urandom; operandB = $urandom;
    if (op >= 3'd6) check({tag, "_busy"}, busy, 1);
    cyc = 0;
    while (!done && cyc < N + 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_lat"}, cyc, (op >= 3'd6) ? N : 0);
    check({tag, "_busy_done"}, busy, 0);
    check_outputs(tag, er, ec, eo);
    last_res = er;
  endtask

  task automatic hold_check(input string tag);
    @(posedge clk); #1;
    check({tag, "_done_low"}, done, 0);
    check({tag, "_held"}, result, last_res);
  endtask

  initial begin
    logic [31:0] er;
    logic ec, eo;
    int cyc, seen;
    logic [2:0] op;
    logic [31:0] a, b;

    #12;
    check("reset_out", {busy, done, C_Flag, O_Flag, N_Flag, Z_Flag, result}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd1, 32, 32, "sub_zero");
    run_op(3'd0, 32'h7FFF_FFFF, 1, "add_ovf");
    run_op(3'd0, 32'hFFFF_FFFF, 1, "add_carry");
    hold_check("hold1");
    run_op(3'd6, 32'h0001_0000, 32'h0001_0000, "mul_big");
    run_op(3'd6, 6, 7, "mul_small");
    run_op(3'd7, 100, 7, "div");
    run_op(3'd7, 5, 0, "div0");
    hold_check("hold2");
    run_op(3'd5, 32'h8000_0001, 1, "shl1");
    run_op(3'd5, 32'h1234_5678, 0, "shl0");

    // A start raised mid-MUL must be ignored; ADD issued in the done cycle is taken.
    model(3'd6, 6, 7, er, ec, eo);
    @(negedge clk);
    start = 1'b1; opcode = 3'd6; operandA = 6; operandB = 7;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < N + 8) begin
      @(negedge clk);
      start = (cyc == 5); opcode = 3'd0; operandA = 1; operandB = 1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    check("hs_lat", cyc, N);
    check_outputs("hs_mul", er, ec, eo);
    run_op(3'd0, 1, 1, "hs_add");

    // Reset during DIV abandons it.
    @(negedge clk);
    start = 1'b1; opcode = 3'd7; operandA = 100; operandB = 7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_out", {busy, done, C_Flag, O_Flag, N_Flag, Z_Flag, result}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (N + 4) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("rst_no_done", seen, 0);
    run_op(3'd5, 1, 31, "shl_after_rst");

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 0;
        1: b = b >> $urandom_range(0, 31);
        2: a = a >> $urandom_range(0, 31);
        default: ;
      endcase
      run_op(op, a, b, $sformatf("rnd%0d_op%0d", i, op));
      if (i % 8 == 7) hold_check($sformatf("rnd%0d_hold", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
